led_pwm_sb_ctrl: RTL and testbench

LED_PWM_SB_CTRL -- requirements
Module: led_pwm_sb_ctrl

---
 rtl/led_pwm_sb_ctrl.sv | 133 +++++++++++++
 tb/tb_led_pwm_sb_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_sb_ctrl.sv
// LED controller on a simple request bus: static, blink, PWM and blink+PWM
// modes, with a small register window and a soft-reset register.
module led_pwm_sb_ctrl #(
  parameter int unsigned LED_W       = 16,
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned PWM_BITS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             write_enable_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o,
  output logic [LED_W-1:0] led_o
);

  localparam logic [31:0] HALF_RST  = 32'(CLK_FREQ_HZ);
  // 33-bit limits so LED_W / PWM_BITS up to 32 still give a valid bound
  localparam logic [32:0] VALUE_LIM = 33'd1 << LED_W;
  localparam logic [32:0] DUTY_LIM  = 33'd1 << PWM_BITS;

  localparam logic [31:0] OFF_VALUE = 32'h00;
  localparam logic [31:0] OFF_MODE  = 32'h04;
  localparam logic [31:0] OFF_HALF  = 32'h08;
  localparam logic [31:0] OFF_DUTY  = 32'h0C;
  localparam logic [31:0] OFF_SRST  = 32'h24;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] off;
    logic [31:0] data;
  } bus_req_t;

  bus_req_t              breq;
  logic [LED_W-1:0]      value_q;
  logic [1:0]            mode_q;
  logic [31:0]           half_q;
  logic [PWM_BITS-1:0]   duty_q;
  logic [31:0]           bcnt_q;
  logic [PWM_BITS-1:0]   pcnt_q;

  logic                  wr_value, wr_mode, wr_half, wr_duty, soft_rst, cnt_clr;
  logic [32:0]           bcnt_inc;
  logic                  bcnt_wrap, blink_on, pwm_on, led_on;
  logic [31:0]           rdata_nxt;

  // Bus decode: offsets are exact matches, anything else is unmapped.
  always_comb begin
    breq.wr   = req_i & write_enable_i;
    breq.rd   = req_i & ~write_enable_i;
    breq.off  = addr_i - BASE_ADDR;
    breq.data = write_data_i;
    wr_value  = breq.wr && (breq.off == OFF_VALUE) && ({1'b0, breq.data} < VALUE_LIM);
    wr_mode   = breq.wr && (breq.off == OFF_MODE)  && (breq.data < 32'd4);
    wr_half   = breq.wr && (breq.off == OFF_HALF)  && (breq.data != 32'd0);
    wr_duty   = breq.wr && (breq.off == OFF_DUTY)  && ({1'b0, breq.data} < DUTY_LIM);
    soft_rst  = breq.wr && (breq.off == OFF_SRST)  && (breq.data == 32'd1);
    cnt_clr   = wr_mode | wr_half;
  end

  // Pattern generation; wrap test in 33 bits so 2*HALF_PERIOD never overflows.
  always_comb begin
    bcnt_inc  = {1'b0, bcnt_q} + 33'd1;
    bcnt_wrap = bcnt_inc >= {half_q, 1'b0};
    blink_on  = bcnt_q < half_q;
    pwm_on    = pcnt_q < duty_q;
    led_on    = (~mode_q[0] | blink_on) & (~mode_q[1] | pwm_on);
  end

  // Read mux: zero-extended register value, 0 for write-only/unmapped.
  always_comb begin
    rdata_nxt = '0;
    case (breq.off)
      OFF_VALUE: rdata_nxt[LED_W-1:0]    = value_q;
      OFF_MODE:  rdata_nxt[1:0]          = mode_q;
      OFF_HALF:  rdata_nxt               = half_q;
      OFF_DUTY:  rdata_nxt[PWM_BITS-1:0] = duty_q;
      default:   rdata_nxt               = '0;
    endcase
  end

  // Configuration registers; soft reset wins over any other update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
      mode_q  <= '0;
      half_q  <= HALF_RST;
      duty_q  <= '0;
    end else if (soft_rst) begin
      value_q <= '0;
      mode_q  <= '0;
      half_q  <= HALF_RST;
      duty_q  <= '0;
    end else begin
      if (wr_value) value_q <= breq.data[LED_W-1:0];
      if (wr_mode)  mode_q  <= breq.data[1:0];
      if (wr_half)  half_q  <= breq.data;
      if (wr_duty)  duty_q  <= breq.data[PWM_BITS-1:0];
    end
  end

  // Blink and PWM counters; restarted by any change of mode or half-period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q <= '0;
      pcnt_q <= '0;
    end else if (soft_rst || cnt_clr) begin
      bcnt_q <= '0;
      pcnt_q <= '0;
    end else begin
      bcnt_q <= (mode_q[0] && !bcnt_wrap) ? bcnt_inc[31:0] : '0;
      pcnt_q <= mode_q[1] ? pcnt_q + PWM_BITS'(1) : '0;
    end
  end

  // Registered read data; holds when no read is requested.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       read_data_o <= '0;
    else if (soft_rst) read_data_o <= '0;
    else if (breq.rd)  read_data_o <= rdata_nxt;
  end

  // Registered LED drive from the current pattern state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       led_o <= '0;
    else if (soft_rst) led_o <= '0;
    else               led_o <= led_on ? value_q : '0;
  end

endmodule

// File: tb/tb_led_pwm_sb_ctrl.sv
// Bench for led_pwm_sb_ctrl: directed scenarios plus random bus traffic
// compared against a time-based behavioural model.
module tb_led_pwm_sb_ctrl;
  localparam int          LW = 16;
  localparam int          PB = 8;
  localparam int          CF = 10_000_000;
  localparam logic [31:0] BA = 32'h0200_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [LW-1:0] led;

  always #5 clk = ~clk;

  led_pwm_sb_ctrl #(.LED_W(LW), .CLK_FREQ_HZ(CF), .PWM_BITS(PB), .BASE_ADDR(BA)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_enable_i(we),
    .addr_i(addr), .write_data_i(wdata), .read_data_o(rdata), .led_o(led)
  );

  int checks = 0;
  int errors = 0;

  // Model: register contents plus elapsed cycles since each pattern restarted.
  logic [LW-1:0] m_value;
  logic [1:0]    m_mode;
  logic [31:0]   m_half;
  logic [31:0]   m_duty;
  longint        m_tb, m_tp;
  logic [LW-1:0] exp_led;
  logic [31:0]   exp_rd;

  task automatic model_reset();
    m_value = '0; m_mode = '0; m_half = CF; m_duty = '0;
    m_tb = 0; m_tp = 0; exp_led = '0; exp_rd = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] off);
    case (off)
      32'h00:  return {16'h0, m_value};
      32'h04:  return {30'h0, m_mode};
      32'h08:  return m_half;
      32'h0C:  return m_duty;
      default: return 32'h0;
    endcase
  endfunction

  // Effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    logic [31:0] off;
    logic        wr, rd, on_b, on_p, on;
    longint      h;
    off  = addr - BA;
    wr   = req && we;
    rd   = req && !we;
    h    = longint'(m_half);
    on_b = (m_tb % (2 * h)) < h;
    on_p = (m_tp % (1 << PB)) < longint'(m_duty);
    case (m_mode)
      2'd0: on = 1'b1;
      2'd1: on = on_b;
      2'd2: on = on_p;
      default: on = on_b && on_p;
    endcase
    if (wr && off == 32'h24 && wdata == 32'd1) begin
      model_reset();
      return;
    end
    exp_led = on ? m_value : '0;
    if (rd) exp_rd = model_read(off);
    m_tb = m_mode[0] ? m_tb + 1 : 0;
    m_tp = m_mode[1] ? m_tp + 1 : 0;
    if (wr) begin
      if (off == 32'h00 && wdata < 32'h1_0000) m_value = wdata[LW-1:0];
      if (off == 32'h04 && wdata <= 32'd3) begin m_mode = wdata[1:0]; m_tb = 0; m_tp = 0; end
      if (off == 32'h08 && wdata != 32'd0) begin m_half = wdata; m_tb = 0; m_tp = 0; end
      if (off == 32'h0C && wdata < 32'd256) m_duty = wdata;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [31:0] off, input logic [31:0] d);
    req = 1'b1; we = w; addr = BA + off; wdata = d;
    step();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_regs [4];
    exp_regs = '{32'h0, 32'h0, CF, 32'h0};
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++; if (led !== '0) begin errors++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 32'(i * 4), 32'h0);
      checks++;
      if (rdata !== exp_regs[i]) begin
        errors++; $display("FAIL reset_reg%0d got=%h exp=%h", i, rdata, exp_regs[i]);
      end
    end
  endtask

  task automatic test_static();
    bus(1'b1, 32'h04, 32'd0);
    bus(1'b1, 32'h00, 32'hA5A5);
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL static_latency got=%h exp=%h", led, 16'h0); end
    step();
    checks++; if (led !== 16'hA5A5) begin errors++; $display("FAIL static_led got=%h exp=%h", led, 16'hA5A5); end
    bus(1'b0, 32'h00, 32'h0);
    checks++; if (rdata !== 32'h0000_A5A5) begin errors++; $display("FAIL static_read got=%h exp=%h", rdata, 32'hA5A5); end
  endtask

  task automatic test_invalid();
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    exp_a = '{32'hA5A5, 32'h0, CF, 32'h0};
    exp_b = '{32'hFFFF, 32'h3, 32'h1, 32'hFF};
    bus(1'b1, 32'h00, 32'h1_0000);
    bus(1'b1, 32'h04, 32'd4);
    bus(1'b1, 32'h08, 32'd0);
    bus(1'b1, 32'h0C, 32'h100);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 32'(i * 4), 32'h0);
      checks++;
      if (rdata !== exp_a[i]) begin errors++; $display("FAIL invalid_reg%0d got=%h exp=%h", i, rdata, exp_a[i]); end
    end
    for (int i = 0; i < 4; i++) bus(1'b1, 32'(i * 4), exp_b[i]);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 32'(i * 4), 32'h0);
      checks++;
      if (rdata !== exp_b[i]) begin errors++; $display("FAIL edge_valid_reg%0d got=%h exp=%h", i, rdata, exp_b[i]); end
    end
    bus(1'b1, 32'h04, 32'd0);
  endtask

  task automatic test_blink();
    logic [LW-1:0] e;
    bus(1'b1, 32'h08, 32'd5);
    bus(1'b1, 32'h00, 32'h000F);
    bus(1'b1, 32'h04, 32'd1);
    step();
    for (int k = 0; k < 30; k++) begin
      e = ((k % 10) < 5) ? 16'h000F : 16'h0;
      checks++; if (led !== e) begin errors++; $display("FAIL blink5_k%0d got=%h exp=%h", k, led, e); end
      step();
    end
    bus(1'b1, 32'h08, 32'd3);
    step();
    for (int k = 0; k < 18; k++) begin
      e = ((k % 6) < 3) ? 16'h000F : 16'h0;
      checks++; if (led !== e) begin errors++; $display("FAIL blink3_k%0d got=%h exp=%h", k, led, e); end
      step();
    end
  endtask

  task automatic test_pwm();
    int on_cnt, bad;
    bus(1'b1, 32'h0C, 32'd64);
    bus(1'b1, 32'h00, 32'hFFFF);
    bus(1'b1, 32'h04, 32'd2);
    step();
    on_cnt = 0; bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (led === 16'hFFFF) on_cnt++;
      if (led !== (((k % 256) < 64) ? 16'hFFFF : 16'h0)) bad++;
      step();
    end
    checks++; if (on_cnt != 64) begin errors++; $display("FAIL pwm_on_count got=%0d exp=%0d", on_cnt, 64); end
    checks++; if (bad != 0) begin errors++; $display("FAIL pwm_phase bad_cycles got=%0d exp=%0d", bad, 0); end
    bus(1'b1, 32'h0C, 32'd0);
    step();
    on_cnt = 0;
    repeat (300) begin
      if (led !== 16'h0) on_cnt++;
      step();
    end
    checks++; if (on_cnt != 0) begin errors++; $display("FAIL pwm_duty0 lit_cycles got=%0d exp=%0d", on_cnt, 0); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] exp_regs [4];
    exp_regs = '{32'h0, 32'h0, CF, 32'h0};
    bus(1'b1, 32'h08, 32'd4);
    bus(1'b1, 32'h00, 32'h3);
    bus(1'b1, 32'h04, 32'd1);
    repeat (3) step();
    bus(1'b1, 32'h24, 32'd2);
    bus(1'b0, 32'h04, 32'h0);
    checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL srst2_mode got=%h exp=%h", rdata, 32'd1); end
    bus(1'b0, 32'h08, 32'h0);
    checks++; if (rdata !== 32'd4) begin errors++; $display("FAIL srst2_half got=%h exp=%h", rdata, 32'd4); end
    step();
    bus(1'b1, 32'h24, 32'd1);
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL srst_led got=%h exp=%h", led, 16'h0); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL srst_rdata got=%h exp=%h", rdata, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 32'(i * 4), 32'h0);
      checks++;
      if (rdata !== exp_regs[i]) begin errors++; $display("FAIL srst_reg%0d got=%h exp=%h", i, rdata, exp_regs[i]); end
    end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL srst_led_after got=%h exp=%h", led, 16'h0); end
  endtask

  task automatic test_async_reset();
    int lit;
    bus(1'b1, 32'h00, 32'h1234);
    step();
    bus(1'b0, 32'h00, 32'h0);
    checks++; if (led !== 16'h1234) begin errors++; $display("FAIL async_pre_led got=%h exp=%h", led, 16'h1234); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL async_led got=%h exp=%h", led, 16'h0); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata got=%h exp=%h", rdata, 32'h0); end
    #1 rst_n = 1'b1;
    model_reset();
    lit = 0;
    repeat (6) begin
      step();
      if (led !== 16'h0) lit++;
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL async_led_stays0 lit_cycles got=%0d exp=%0d", lit, 0); end
  endtask

  task automatic test_unmapped();
    bus(1'b1, 32'h00, 32'h0077);
    bus(1'b0, 32'h00, 32'h0);
    checks++; if (rdata !== 32'h77) begin errors++; $display("FAIL unm_value got=%h exp=%h", rdata, 32'h77); end
    bus(1'b0, 32'h10, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unm_read10 got=%h exp=%h", rdata, 32'h0); end
    bus(1'b0, 32'h00, 32'h0);
    repeat (3) step();
    checks++; if (rdata !== 32'h77) begin errors++; $display("FAIL unm_hold got=%h exp=%h", rdata, 32'h77); end
    bus(1'b0, 32'h24, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unm_read24 got=%h exp=%h", rdata, 32'h0); end
    bus(1'b1, 32'h10, 32'hFFFF_FFFF);
    bus(1'b1, 32'h40, 32'h5);
    bus(1'b0, 32'h00, 32'h0);
    checks++; if (rdata !== 32'h77) begin errors++; $display("FAIL unm_wr_value got=%h exp=%h", rdata, 32'h77); end
    bus(1'b0, 32'h04, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unm_wr_mode got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_random();
    int          sel;
    logic [31:0] off, d;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        step();
      end else begin
        sel = $urandom_range(0, 40);
        if (sel < 10)      begin off = 32'h00; d = $urandom_range(0, 32'h1_0010); end
        else if (sel < 18) begin off = 32'h04; d = $urandom_range(0, 5); end
        else if (sel < 26) begin off = 32'h08; d = $urandom_range(0, 7); end
        else if (sel < 36) begin off = 32'h0C; d = $urandom_range(0, 270); end
        else if (sel < 37) begin off = 32'h24; d = $urandom_range(0, 2); end
        else if (sel < 39) begin off = 32'h10; d = $urandom; end
        else               begin off = $urandom & 32'hFC; d = $urandom; end
        bus($urandom_range(0, 1) == 1, off, d);
      end
      checks++;
      if (led !== exp_led) begin errors++; $display("FAIL rand_led n=%0d got=%h exp=%h", n, led, exp_led); end
      checks++;
      if (rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, rdata, exp_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_invalid();
    test_blink();
    test_pwm();
    test_soft_reset();
    test_async_reset();
    test_unmapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
